// File: rtl/input_debounce.sv
// Per-bit synchronizer and debouncer with a shared sample prescaler.
// Optional macro INPUT_DEBOUNCE_SYNC_EN inserts a two-flop synchronizer ahead of the debounce logic.
module input_debounce #(
  parameter int   IW  = 1,
  parameter logic DS  = 1'b0,
  parameter int   PS  = 1,
  parameter int   DLY = 4,
  parameter int   CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] i,
  output logic [IW-1:0] o,
  output logic [IW-1:0] o_rise,
  output logic [IW-1:0] o_fall,
  output logic          o_tick
);

  localparam int             PW       = (PS > 1) ? $clog2(PS) : 1;
  localparam logic [PW-1:0]  PCNT_END = PW'(PS - 1);
  localparam logic [CW-1:0]  CNT_END  = CW'(DLY - 1);

  logic [IW-1:0] s;
  logic [PW-1:0] pcnt;
  logic          tick;
  logic [CW-1:0] cnt [IW];

`ifdef INPUT_DEBOUNCE_SYNC_EN
  logic [IW-1:0] sync_q1;
  logic [IW-1:0] sync_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= {IW{DS}};
      sync_q2 <= {IW{DS}};
    end else begin
      sync_q1 <= i;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = i;
`endif

  // With PS == 1 pcnt never leaves 0, so the tick is permanently high.
  assign tick   = (pcnt == PCNT_END);
  assign o_tick = tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Any sample agreeing with the stable level restarts the count, so only
  // DLY consecutive differing ticks can move o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o      <= {IW{DS}};
      o_rise <= '0;
      o_fall <= '0;
      for (int n = 0; n < IW; n++) begin
        cnt[n] <= '0;
      end
    end else begin
      o_rise <= '0;
      o_fall <= '0;
      for (int n = 0; n < IW; n++) begin
        if (s[n] == o[n]) begin
          cnt[n] <= '0;
        end else if (tick && (cnt[n] == CNT_END)) begin
          o[n]      <= s[n];
          cnt[n]    <= '0;
          o_rise[n] <= s[n];
          o_fall[n] <= ~s[n];
        end else if (tick) begin
          cnt[n] <= cnt[n] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_input_debounce.sv
// Directed scoreboard bench for input_debounce: three instances (PS=1/DS=0, PS=3/DS=0, PS=1/DS=1).
// Latencies follow INPUT_DEBOUNCE_SYNC_EN as seen by the bench.
module tb_input_debounce;

  localparam int IW  = 2;
  localparam int DLY = 4;
  localparam int PSB = 3;
`ifdef INPUT_DEBOUNCE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  typedef struct packed {
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] o;
    int         cmin;
    int         cmax;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] ia = 2'b00;
  logic [IW-1:0] ib = 2'b00;
  logic [IW-1:0] ic = 2'b11;
  logic [IW-1:0] oa, ra, fa, ob, rb, fb, oc, rc, fc;
  logic          ta, tb, tc;

  ev_t q[3][$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  always #5 clk = ~clk;

  input_debounce #(.IW(IW), .DS(1'b0), .PS(1), .DLY(DLY), .CW(8)) dut_a (
    .clk(clk), .rst(rst), .i(ia), .o(oa), .o_rise(ra), .o_fall(fa), .o_tick(ta));

  input_debounce #(.IW(IW), .DS(1'b0), .PS(PSB), .DLY(DLY), .CW(8)) dut_b (
    .clk(clk), .rst(rst), .i(ib), .o(ob), .o_rise(rb), .o_fall(fb), .o_tick(tb));

  input_debounce #(.IW(IW), .DS(1'b1), .PS(1), .DLY(DLY), .CW(8)) dut_c (
    .clk(clk), .rst(rst), .i(ic), .o(oc), .o_rise(rc), .o_fall(fc), .o_tick(tc));

  task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
    checks++;
    assert (got >= lo && got <= hi) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic expect_ev(input int k, input logic [1:0] r, input logic [1:0] f,
                           input logic [1:0] ov, input int lo, input int hi);
    ev_t e;
    e.rise = r;
    e.fall = f;
    e.o    = ov;
    e.cmin = lo;
    e.cmax = hi;
    q[k].push_back(e);
  endtask

  task automatic mon(input int k, input logic [1:0] r, input logic [1:0] f, input logic [1:0] ov);
    ev_t e;
    if ((r | f) != 2'b00) begin
      if (q[k].size() == 0) begin
        chk2($sformatf("unexpected_pulse_%0d", k), r | f, 2'b00);
      end else begin
        e = q[k].pop_front();
        chk2($sformatf("rise_%0d", k), r, e.rise);
        chk2($sformatf("fall_%0d", k), f, e.fall);
        chk2($sformatf("o_at_pulse_%0d", k), ov, e.o);
        chk_rng($sformatf("latency_%0d", k), cyc, e.cmin, e.cmax);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    mon(0, ra, fa, oa);
    mon(1, rb, fb, ob);
    mon(2, rc, fc, oc);
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < maxc) begin
      tick();
      n++;
    end
    chk_rng("pending_events", q[0].size() + q[1].size() + q[2].size(), 0, 0);
  endtask

  initial begin
    int c;
    int r;

    // reset and idle
    repeat (3) tick();
    rst = 1'b0;
    chk2("reset_o", oa, 2'b00);
    chk2("reset_rise", ra, 2'b00);
    chk2("reset_fall", fa, 2'b00);
    chk2("reset_tick_ps1", {1'b0, ta}, 2'b01);
    chk2("reset_tick_ps3", {1'b0, tb}, 2'b00);
    chk2("reset_o_ds1", oc, 2'b11);
    for (int t = 0; t < 20; t++) begin
      tick();
      chk2("idle_o", oa, 2'b00);
    end

    // clean press and release
    ia = 2'b01;
    c = cyc;
    expect_ev(0, 2'b01, 2'b00, 2'b01, c + SL + DLY, c + SL + DLY);
    repeat (10) tick();
    ia = 2'b00;
    c = cyc;
    expect_ev(0, 2'b00, 2'b01, 2'b00, c + SL + DLY, c + SL + DLY);
    drain(20);

    // 3-clock glitch is rejected
    ia = 2'b10;
    repeat (3) tick();
    ia = 2'b00;
    repeat (15) tick();
    chk2("glitch_o", oa, 2'b00);
    drain(0);

    // 4-clock pulse is accepted
    ia = 2'b10;
    c = cyc;
    expect_ev(0, 2'b10, 2'b00, 2'b10, c + SL + DLY, c + SL + DLY);
    repeat (4) tick();
    ia = 2'b00;
    c = cyc;
    expect_ev(0, 2'b00, 2'b10, 2'b00, c + SL + DLY, c + SL + DLY);
    drain(20);

    // bounce then settle high
    for (int t = 0; t < 6; t++) begin
      ia = (t % 2 == 0) ? 2'b01 : 2'b00;
      repeat (2) tick();
    end
    ia = 2'b01;
    c = cyc;
    expect_ev(0, 2'b01, 2'b00, 2'b01, c + SL + DLY, c + SL + DLY);
    drain(20);
    ia = 2'b00;
    c = cyc;
    expect_ev(0, 2'b00, 2'b01, 2'b00, c + SL + DLY, c + SL + DLY);
    drain(20);

    // both bits at once with PS=3, random phase
    repeat (int'($urandom_range(0, 2))) tick();
    ib = 2'b11;
    c = cyc;
    expect_ev(1, 2'b11, 2'b00, 2'b11, c + SL + (DLY - 1) * PSB + 1, c + SL + DLY * PSB);
    drain(30);
    repeat (int'($urandom_range(0, 2))) tick();
    ib = 2'b00;
    c = cyc;
    expect_ev(1, 2'b00, 2'b11, 2'b00, c + SL + (DLY - 1) * PSB + 1, c + SL + DLY * PSB);
    drain(30);

    // reset mid-count restarts the full latency
    ia = 2'b01;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk2("midreset_o", oa, 2'b00);
    chk2("midreset_rise", ra, 2'b00);
    tick();
    rst = 1'b0;
    r = cyc;
    chk2("after_reset_o", oa, 2'b00);
    expect_ev(0, 2'b01, 2'b00, 2'b01, r + SL + DLY, r + SL + DLY);
    drain(20);

    // DS=1 instance with inputs low through reset
    rst = 1'b1;
    ia = 2'b00;
    ic = 2'b00;
    #1;
    chk2("ds1_reset_o", oc, 2'b11);
    chk2("reset_clears_o", oa, 2'b00);
    tick();
    rst = 1'b0;
    r = cyc;
    expect_ev(2, 2'b00, 2'b11, 2'b00, r + SL + DLY, r + SL + DLY);
    drain(20);
    repeat (5) tick();
    chk2("final_o_ds1", oc, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
